// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART transmit path: data width, default FIFO sizing
// and the bit positions of the FIFO flags inside the status register.
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_AF_DEF    = 12;

  localparam int ST_EMPTY_BIT    = 0;
  localparam int ST_FULL_BIT     = 1;
  localparam int ST_ALMOST_BIT   = 2;
  localparam int ST_OVERFLOW_BIT = 3;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle between the register interface / transmit controller and the TX FIFO.
// The FIFO sits on the slave modport; whoever drives pushes and controller handshakes uses master.
interface uart_tx_fifo_if #(
  parameter int DEPTH = uart_tx_fifo_pkg::FIFO_DEPTH_DEF
);
  import uart_tx_fifo_pkg::*;

  logic                   wr_valid;
  uart_byte_t             wr_data;
  logic                   wr_ready;
  logic                   flush;
  logic                   clear_overflow;
  logic                   tx_enable;
  logic                   tx_ready;
  logic                   tx_w_en;
  uart_byte_t             tx_w_data;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;
  logic                   almost_full;
  logic                   overflow;

  modport master (
    output wr_valid, wr_data, flush, clear_overflow, tx_enable, tx_ready,
    input  wr_ready, tx_w_en, tx_w_data, count, empty, full, almost_full, overflow
  );

  modport slave (
    input  wr_valid, wr_data, flush, clear_overflow, tx_enable, tx_ready,
    output wr_ready, tx_w_en, tx_w_data, count, empty, full, almost_full, overflow
  );

endinterface

// File: rtl/uart_tx_fifo_ram.sv
// FIFO storage: DEPTH bytes, synchronous write, asynchronous read so the head
// byte can be presented first-word-fall-through. Contents are deliberately not reset.
module uart_fifo_ram
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  uart_byte_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output uart_byte_t        rdata
);

  uart_byte_t mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmit controller: pointer/flag/overflow logic around
// uart_fifo_ram. A byte leaves on the exact cycle the controller accepts it.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_THRESH = FIFO_AF_DEF
) (
  input  logic           Clk,
  input  logic           Resetn,
  uart_tx_fifo_if.slave  bus
);

  localparam int              ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);

  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [ADDR_W:0] count_q;
  logic            empty_q, full_q, almost_full_q, overflow_q;
  logic            push, pop, overflow_evt;
  uart_byte_t      ram_rdata;

  // Flush wins over everything; otherwise push and pop advance independently.
  always_comb begin
    push         = bus.wr_valid & ~full_q;
    pop          = bus.tx_enable & bus.tx_ready & ~empty_q;
    overflow_evt = bus.wr_valid & full_q;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + 1'b1;
      if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
    end
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      count_q       <= count_nxt;
      empty_q       <= (count_nxt == '0);
      full_q        <= (count_nxt == DEPTH_C);
      almost_full_q <= (count_nxt >= AF_C);
      // A new overflow event beats a simultaneous clear.
      if (overflow_evt)            overflow_q <= 1'b1;
      else if (bus.clear_overflow) overflow_q <= 1'b0;
    end
  end

  uart_fifo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .Clk   (Clk),
    .we    (push & ~bus.flush),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.wr_ready    = ~full_q;
  assign bus.tx_w_en     = ~empty_q;
  assign bus.tx_w_data   = empty_q ? '0 : ram_rdata;
  assign bus.count       = count_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, fill/overflow, controller-style pops,
// pointer wrap against a queue model, full+pop corner, flush and async reset.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic Clk = 1'b0;
  logic Resetn;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic wv, input logic [7:0] wd, input logic en,
                                input logic rdy, input logic fl, input logic clr);
    bus.wr_valid       = wv;
    bus.wr_data        = wd;
    bus.tx_enable      = en;
    bus.tx_ready       = rdy;
    bus.flush          = fl;
    bus.clear_overflow = clr;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    apply_stimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_empty"},    bus.empty, 1);
    check_output({tag, "_full"},     bus.full, 0);
    check_output({tag, "_wr_ready"}, bus.wr_ready, 1);
    check_output({tag, "_w_en"},     bus.tx_w_en, 0);
    check_output({tag, "_w_data"},   bus.tx_w_data, 8'h00);
    check_output({tag, "_count"},    bus.count, 0);
    check_output({tag, "_af"},       bus.almost_full, 0);
    check_output({tag, "_ovf"},      bus.overflow, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] model [$];
    logic [7:0] next_byte;
    logic       do_push, do_pop;

    // Test 1: reset values and single push with controller disabled
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    Resetn = 1'b0;
    #12;
    check_reset_values("rst");
    Resetn = 1'b1;
    apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("t1_w_en", bus.tx_w_en, 1);
    check_output("t1_w_data", bus.tx_w_data, 8'hA5);
    check_output("t1_count", bus.count, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("t1_no_pop", bus.count, 1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("t1_popped", bus.count, 0);
    check_output("t1_empty", bus.empty, 1);

    // Test 2: fill, almost_full threshold, overflow set/clear, ordered drain
    for (int i = 0; i < DEPTH; i++) begin
      check_output("t2_af_pre", bus.almost_full, (i >= AF) ? 1 : 0);
      push_byte(8'(i));
    end
    check_output("t2_full", bus.full, 1);
    check_output("t2_wr_ready", bus.wr_ready, 0);
    check_output("t2_af", bus.almost_full, 1);
    check_output("t2_count", bus.count, 16);
    push_byte(8'hFF);
    check_output("t2_ovf", bus.overflow, 1);
    check_output("t2_drop_cnt", bus.count, 16);
    apply_stimulus(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("t2_set_wins", bus.overflow, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("t2_ovf_clr", bus.overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      check_output("t2_drain", bus.tx_w_data, 8'(i));
      tick();
    end
    check_output("t2_empty", bus.empty, 1);
    check_output("t2_w_data0", bus.tx_w_data, 8'h00);

    // Test 3: controller-paced pops of "HI", Ready pulses once per frame
    push_byte(8'h48);
    push_byte(8'h49);
    check_output("t3_count2", bus.count, 2);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check_output("t3_hold_data", bus.tx_w_data, 8'h48);
    check_output("t3_hold_cnt", bus.count, 2);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check_output("t3_count1", bus.count, 1);
    check_output("t3_data2", bus.tx_w_data, 8'h49);
    repeat (3) tick();
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check_output("t3_count0", bus.count, 0);
    check_output("t3_w_en_low", bus.tx_w_en, 0);

    // Test 4: pointer wrap with occupancy held between 3 and 5
    next_byte = 8'h00;
    for (int i = 0; i < 4; i++) begin
      model.push_back(next_byte);
      push_byte(next_byte);
      next_byte++;
    end
    for (int i = 0; i < 40; i++) begin
      do_push = (i % 3 != 2) && (model.size() < 5);
      do_pop  = (i % 3 != 0) && (model.size() > 3);
      apply_stimulus(do_push, next_byte, do_pop, do_pop, 1'b0, 1'b0);
      if (do_pop) check_output("t4_head", bus.tx_w_data, model[0]);
      tick();
      if (do_pop) void'(model.pop_front());
      if (do_push) begin
        model.push_back(next_byte);
        next_byte++;
      end
      check_output("t4_count", bus.count, model.size());
    end
    while (model.size() > 0) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      check_output("t4_tail", bus.tx_w_data, model[0]);
      tick();
      void'(model.pop_front());
    end
    check_output("t4_empty", bus.empty, 1);

    // Test 5: full with write attempt and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i));
    apply_stimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("t5_count", bus.count, 15);
    check_output("t5_ovf", bus.overflow, 1);
    check_output("t5_full", bus.full, 0);
    for (int i = 1; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      check_output("t5_drain", bus.tx_w_data, 8'(8'h10 + i));
      tick();
    end
    check_output("t5_no_ee", bus.empty, 1);

    // Test 6: flush with concurrent push/pop, then asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
    check_output("t6_count5", bus.count, 5);
    apply_stimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t6_flush_cnt", bus.count, 0);
    check_output("t6_flush_empty", bus.empty, 1);
    check_output("t6_flush_data", bus.tx_w_data, 8'h00);
    check_output("t6_ovf_kept", bus.overflow, 1);
    tick();
    check_output("t6_push_ignored", bus.count, 0);
    for (int i = 0; i < 3; i++) push_byte(8'(8'h50 + i));
    check_output("t6_count3", bus.count, 3);
    #2;
    Resetn = 1'b0;
    #1;
    check_reset_values("t6_async");
    #10;
    Resetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
